// File: rtl/csb_arb_2to1_if.sv
// CSB request/response bundle: master drives the request, slave answers with ready and a response pulse.
// Identical on both sides of the arbiter so masters and the core port share one type.
interface csb_if;
  logic        csb_valid;
  logic        csb_ready;
  logic [15:0] csb_addr;
  logic [31:0] csb_wdat;
  logic        csb_write;
  logic        csb_nposted;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output csb_valid, csb_addr, csb_wdat, csb_write, csb_nposted,
    input  csb_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  csb_valid, csb_addr, csb_wdat, csb_write, csb_nposted,
    output csb_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/csb_arb_2to1.sv
// Round-robin 2:1 CSB arbiter, one outstanding non-posted access; request and response paths are 0-cycle.
// Backpressure: core ready goes only to the granted master in IDLE; grant is locked until its handshake.
module csb_arb_2to1 #(
  parameter int          RSP_TIMEOUT  = 1024,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic   pclk,
  input  logic   prstn,
  csb_if.slave   m0,
  csb_if.slave   m1,
  csb_if.master  nv,
  output logic   timeout_err,
  output logic   stray_rsp
);

  localparam logic [0:0]  ST_IDLE  = 1'b0;
  localparam logic [0:0]  ST_WAIT  = 1'b1;
  localparam logic [15:0] CNT_LAST = 16'(RSP_TIMEOUT - 1);

  logic [0:0]  r_state;
  logic        r_rr_pri;
  logic        r_lock;
  logic        r_lock_id;
  logic        r_owner;
  logic [15:0] r_cnt;

  logic        w_gnt_vld;
  logic        w_gnt_id;
  logic        w_req;
  logic        w_sel_valid;
  logic [15:0] w_sel_addr;
  logic [31:0] w_sel_wdat;
  logic        w_sel_write;
  logic        w_sel_nposted;
  logic        w_hs;
  logic        w_nonposted;
  logic        w_wait;
  logic        w_rsp_hit;
  logic        w_tmo;
  logic        w_rsp_fire;
  logic [31:0] w_rsp_dat;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = 1'b0;
    if (r_state == ST_IDLE) begin
      if (r_lock) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = r_lock_id;
      end else if (m0.csb_valid && m1.csb_valid) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = r_rr_pri;
      end else if (m0.csb_valid) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = 1'b0;
      end else if (m1.csb_valid) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = 1'b1;
      end
    end
  end

  // Outputs are gated by the reset pin itself so they drop the instant reset asserts.
  assign w_req         = w_gnt_vld & prstn;
  assign w_sel_valid   = w_gnt_id ? m1.csb_valid   : m0.csb_valid;
  assign w_sel_addr    = w_gnt_id ? m1.csb_addr    : m0.csb_addr;
  assign w_sel_wdat    = w_gnt_id ? m1.csb_wdat    : m0.csb_wdat;
  assign w_sel_write   = w_gnt_id ? m1.csb_write   : m0.csb_write;
  assign w_sel_nposted = w_gnt_id ? m1.csb_nposted : m0.csb_nposted;

  assign nv.csb_valid   = w_req & w_sel_valid;
  assign nv.csb_addr    = w_req ? w_sel_addr : 16'h0000;
  assign nv.csb_wdat    = w_req ? w_sel_wdat : 32'h0000_0000;
  assign nv.csb_write   = w_req & w_sel_write;
  assign nv.csb_nposted = w_req & w_sel_nposted;

  assign m0.csb_ready = w_req & ~w_gnt_id & nv.csb_ready;
  assign m1.csb_ready = w_req &  w_gnt_id & nv.csb_ready;

  assign w_hs        = nv.csb_valid & nv.csb_ready;
  assign w_nonposted = ~w_sel_write | w_sel_nposted;

  // A real response in the timeout cycle takes precedence over the timeout completion.
  assign w_wait     = (r_state == ST_WAIT) & prstn;
  assign w_rsp_hit  = w_wait & nv.rsp_valid;
  assign w_tmo      = w_wait & ~nv.rsp_valid & (r_cnt == CNT_LAST);
  assign w_rsp_fire = w_rsp_hit | w_tmo;
  assign w_rsp_dat  = w_rsp_hit ? nv.rsp_data : TIMEOUT_DATA;

  assign m0.rsp_valid = w_rsp_fire & ~r_owner;
  assign m1.rsp_valid = w_rsp_fire &  r_owner;
  assign m0.rsp_data  = m0.rsp_valid ? w_rsp_dat : 32'h0000_0000;
  assign m1.rsp_data  = m1.rsp_valid ? w_rsp_dat : 32'h0000_0000;

  assign timeout_err = w_tmo;
  assign stray_rsp   = prstn & (r_state == ST_IDLE) & nv.rsp_valid;

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      r_state   <= ST_IDLE;
      r_rr_pri  <= 1'b0;
      r_lock    <= 1'b0;
      r_lock_id <= 1'b0;
      r_owner   <= 1'b0;
      r_cnt     <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_rr_pri <= ~w_gnt_id;
            r_lock   <= 1'b0;
            if (w_nonposted) begin
              r_owner <= w_gnt_id;
              r_cnt   <= 16'h0000;
              r_state <= ST_WAIT;
            end
          end else if (nv.csb_valid) begin
            r_lock    <= 1'b1;
            r_lock_id <= w_gnt_id;
          end
        end
        ST_WAIT: begin
          if (w_rsp_fire) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'h0001;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csb_arb_2to1.sv
// Randomised and directed checks of csb_arb_2to1 against a transaction-level reference model.
module tb_csb_arb_2to1;

  localparam int          T  = 8;
  localparam logic [31:0] TD = 32'hDEAD_BEEF;

  logic pclk  = 1'b0;
  logic prstn = 1'b0;
  always #5 pclk = ~pclk;

  csb_if m0_if ();
  csb_if m1_if ();
  csb_if nv_if ();
  logic timeout_err;
  logic stray_rsp;

  csb_arb_2to1 #(.RSP_TIMEOUT(T), .TIMEOUT_DATA(TD)) u_dut (
    .pclk        (pclk),
    .prstn       (prstn),
    .m0          (m0_if),
    .m1          (m1_if),
    .nv          (nv_if),
    .timeout_err (timeout_err),
    .stray_rsp   (stray_rsp)
  );

  int errors = 0;
  int checks = 0;

  // stimulus
  bit          v [2];
  bit          wr[2];
  bit          np[2];
  logic [15:0] ad[2];
  logic [31:0] wd[2];
  bit          acc[2];
  bit          c_rdy;
  bit          r_vld;
  logic [31:0] r_dat;

  // reference model: who owns the outstanding access, how long it has waited,
  // which master is preferred, which master's stalled request holds the grant
  int own  = -1;
  int age  = 0;
  int pref = 0;
  int held = -1;

  // snapshot of the last observed cycle
  logic [50:0] o_req;
  logic [32:0] o_rsp0;
  logic [32:0] o_rsp1;
  logic [3:0]  o_flag;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    m0_if.csb_valid   = v[0];  m1_if.csb_valid   = v[1];
    m0_if.csb_write   = wr[0]; m1_if.csb_write   = wr[1];
    m0_if.csb_nposted = np[0]; m1_if.csb_nposted = np[1];
    m0_if.csb_addr    = ad[0]; m1_if.csb_addr    = ad[1];
    m0_if.csb_wdat    = wd[0]; m1_if.csb_wdat    = wd[1];
    nv_if.csb_ready   = c_rdy;
    nv_if.rsp_valid   = r_vld;
    nv_if.rsp_data    = r_dat;
  endtask

  // One cycle: drive, check outputs mid-cycle, advance the model across the edge.
  task automatic step();
    logic [50:0] e_req;
    logic [32:0] e_rsp0, e_rsp1;
    logic [3:0]  e_flag;
    int g;
    apply();
    #1;
    g = -1; e_req = '0; e_rsp0 = '0; e_rsp1 = '0; e_flag = '0;
    acc[0] = 1'b0; acc[1] = 1'b0;
    if (prstn) begin
      if (own < 0) begin
        if (held >= 0)           g = held;
        else if (v[0] && v[1])   g = pref;
        else if (v[0])           g = 0;
        else if (v[1])           g = 1;
      end
      if (g >= 0) e_req = {v[g], wr[g], np[g], ad[g], wd[g]};
      e_flag[3] = (g == 0) && c_rdy;
      e_flag[2] = (g == 1) && c_rdy;
      if (own >= 0) begin
        if (r_vld) begin
          if (own == 0) e_rsp0 = {1'b1, r_dat}; else e_rsp1 = {1'b1, r_dat};
        end else if (age == T) begin
          if (own == 0) e_rsp0 = {1'b1, TD}; else e_rsp1 = {1'b1, TD};
          e_flag[1] = 1'b1;
        end
      end else begin
        e_flag[0] = r_vld;
      end
    end
    o_req  = {nv_if.csb_valid, nv_if.csb_write, nv_if.csb_nposted, nv_if.csb_addr, nv_if.csb_wdat};
    o_rsp0 = {m0_if.rsp_valid, m0_if.rsp_data};
    o_rsp1 = {m1_if.rsp_valid, m1_if.rsp_data};
    o_flag = {m0_if.csb_ready, m1_if.csb_ready, timeout_err, stray_rsp};
    chk("req_bus", 64'(o_req), 64'(e_req));
    chk("rsp_m0", 64'(o_rsp0), 64'(e_rsp0));
    chk("rsp_m1", 64'(o_rsp1), 64'(e_rsp1));
    chk("rdy_flags", 64'(o_flag), 64'(e_flag));
    if (!prstn) begin
      own = -1; age = 0; pref = 0; held = -1;
    end else if (own >= 0) begin
      if (r_vld || age == T) own = -1;
      else age++;
    end else if (g >= 0) begin
      if (c_rdy) begin
        acc[g] = 1'b1;
        pref   = 1 - g;
        held   = -1;
        if (!wr[g] || np[g]) begin
          own = g;
          age = 1;
        end
      end else begin
        held = g;
      end
    end
    @(negedge pclk);
  endtask

  task automatic set_req(input int n, input bit vv, input bit ww, input bit nn, input logic [15:0] aa, input logic [31:0] dd);
    v[n] = vv; wr[n] = ww; np[n] = nn; ad[n] = aa; wd[n] = dd;
  endtask

  initial begin
    for (int n = 0; n < 2; n++) set_req(n, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    c_rdy = 1'b0; r_vld = 1'b0; r_dat = 32'h0;
    @(negedge pclk);
    set_req(0, 1'b1, 1'b0, 1'b0, 16'h0AAA, 32'h1);
    c_rdy = 1'b1; r_vld = 1'b1;
    step();
    chk("reset_all_zero", 64'({o_req, o_flag}), 64'd0);
    step();
    prstn = 1'b1;
    r_vld = 1'b0;

    // continuous posted writes from both masters
    set_req(0, 1'b1, 1'b1, 1'b0, 16'h0010, 32'h0000_0A00);
    set_req(1, 1'b1, 1'b1, 1'b0, 16'h0020, 32'h0000_0B00);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("posted_alt_addr", 64'(o_req[47:32]), (i % 2 == 0) ? 64'h10 : 64'h20);
    end

    // m1 read, response after 3 cycles, m0 waits for it
    set_req(0, 1'b0, 1'b1, 1'b0, 16'h0010, 32'h0);
    set_req(1, 1'b1, 1'b0, 1'b0, 16'h0100, 32'h0);
    step();
    chk("m1_read_accept", 64'(o_flag[2]), 64'd1);
    set_req(1, 1'b0, 1'b0, 1'b0, 16'h0100, 32'h0);
    set_req(0, 1'b1, 1'b1, 1'b0, 16'h0010, 32'h0000_0C00);
    for (int k = 1; k <= 3; k++) begin
      r_vld = (k == 3);
      r_dat = 32'h1234_5678;
      step();
      chk("m0_blocked", 64'(o_flag[3]), 64'd0);
      chk("m1_rsp", 64'(o_rsp1), (k == 3) ? {31'd0, 1'b1, 32'h1234_5678} : 64'd0);
    end
    r_vld = 1'b0;
    step();
    chk("m0_after_rsp", 64'(o_flag[3]), 64'd1);

    // stalled m0 keeps the grant while m1 competes
    set_req(0, 1'b1, 1'b1, 1'b1, 16'h0030, 32'h0000_0D00);
    c_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) set_req(1, 1'b1, 1'b1, 1'b0, 16'h0040, 32'h0000_0E00);
      step();
      chk("lock_addr", 64'(o_req[47:32]), 64'h30);
    end
    c_rdy = 1'b1;
    step();
    chk("lock_m0_first", 64'(o_flag[3:2]), 64'b10);
    set_req(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    r_vld = 1'b1; r_dat = 32'h0000_A5A5;
    step();
    chk("np_write_cpl", 64'(o_rsp0), {31'd0, 1'b1, 32'h0000_A5A5});
    r_vld = 1'b0;
    step();
    chk("m1_after_lock", 64'(o_flag[2]), 64'd1);
    set_req(1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);

    // timeout with no response
    set_req(0, 1'b1, 1'b0, 1'b0, 16'h0050, 32'h0);
    step();
    chk("tmo_accept", 64'(o_flag[3]), 64'd1);
    set_req(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    for (int k = 1; k <= T; k++) begin
      step();
      chk("tmo_cycle", 64'({o_flag[1], o_rsp0}), (k == T) ? {30'd0, 2'b11, TD} : 64'd0);
    end
    set_req(0, 1'b1, 1'b0, 1'b0, 16'h0054, 32'h0);
    step();
    chk("after_tmo_accept", 64'(o_flag[3]), 64'd1);
    set_req(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    // real response in the timeout cycle wins
    for (int k = 1; k <= T; k++) begin
      r_vld = (k == T);
      r_dat = 32'hCAFE_0001;
      step();
      chk("tmo_race", 64'({o_flag[1], o_rsp0}), (k == T) ? {30'd0, 2'b01, 32'hCAFE_0001} : 64'd0);
    end
    r_vld = 1'b0;

    // stray response while idle
    r_vld = 1'b1; r_dat = 32'h5555_AAAA;
    step();
    chk("stray_pulse", 64'({o_flag[0], o_rsp0[32], o_rsp1[32]}), 64'b100);
    r_vld = 1'b0;
    step();
    chk("stray_clear", 64'(o_flag[0]), 64'd0);

    // reset during WAIT_RSP
    set_req(0, 1'b1, 1'b0, 1'b0, 16'h0060, 32'h0);
    step();
    set_req(1, 1'b1, 1'b0, 1'b0, 16'h0070, 32'h0);
    r_vld = 1'b1; r_dat = 32'h7777_0000;
    prstn = 1'b0;
    step();
    chk("rst_wait_zero", 64'({o_req, o_flag}), 64'd0);
    chk("rst_wait_rsp", 64'({o_rsp0[32], o_rsp1[32]}), 64'd0);
    step();
    prstn = 1'b1;
    step();
    chk("post_rst_m0", 64'(o_flag[3:2]), 64'b10);
    chk("post_rst_stray", 64'(o_flag[0]), 64'd1);
    r_vld = 1'b0;

    // randomised traffic
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!v[n] || acc[n]) begin
          if ($urandom_range(0, 99) < 60)
            set_req(n, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    16'($urandom), $urandom);
          else
            v[n] = 1'b0;
        end
      end
      c_rdy = ($urandom_range(0, 99) < 70);
      r_vld = ($urandom_range(0, 99) < 15);
      r_dat = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
